// File: rtl/apb_multi_slave_bridge.sv
// APB requester-to-multi-slave bridge.
// Each accepted request becomes one APB transfer to the slave picked by the top
// SW address bits. The transfer runs IDLE -> SETUP -> ACCESS and ends with a
// one-cycle Done/Err pulse.
// Optional feature: define APB_TIMEOUT_EN to enable the ACCESS watchdog. After
// TIMEOUT not-ready cycles the transfer is forced to complete with Err=1.
module apb_multi_slave_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      Trans,
  input  logic                      ReadOrWrite,
  input  logic [ADDR_W-1:0]         Address,
  input  logic [DATA_W-1:0]         INPUT_DATA,
  input  logic [DATA_W/8-1:0]       Input_STRB,
  output logic                      Ready,
  output logic                      Done,
  output logic [DATA_W-1:0]         OUT_DATA,
  output logic                      Err,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int SW     = $clog2(NUM_SLV);
  localparam int STRB_W = DATA_W / 8;

  // Reject parameter values the bridge is not built for.
  if ((NUM_SLV < 2) || (NUM_SLV > 8) || ((NUM_SLV & (NUM_SLV - 1)) != 0)) begin : g_bad_num_slv
    $error("NUM_SLV must be a power of two in 2..8");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q;
  logic                ready_q;
  logic                done_q;
  logic                err_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [NUM_SLV-1:0]  psel_q;
  logic [NUM_SLV-1:0]  psel_d;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;

  logic [SW-1:0]       sel_idx;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]          tmo_cnt_q;
`endif

  function automatic logic [NUM_SLV-1:0] onehot(input logic [SW-1:0] idx);
    logic [NUM_SLV-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Decode the slave select for an incoming request and pick out the selected
  // slave's response lanes for the transfer in flight.
  always_comb begin
    psel_d    = onehot(Address[ADDR_W-1 -: SW]);
    sel_idx   = paddr_q[ADDR_W-1 -: SW];
    sel_ready = PREADY[sel_idx];
    sel_err   = PSLVERR[sel_idx];
    sel_rdata = PRDATA[sel_idx*DATA_W +: DATA_W];
  end

  // Transfer FSM with all bus and requester outputs registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      out_data_q <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Trans) begin
            paddr_q  <= Address;
            pwrite_q <= ~ReadOrWrite;
            pwdata_q <= INPUT_DATA;
            // Reads never carry byte strobes.
            pstrb_q  <= ReadOrWrite ? '0 : Input_STRB;
            psel_q   <= psel_d;
            ready_q  <= 1'b0;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (sel_ready) begin
            done_q    <= 1'b1;
            err_q     <= sel_err;
            if (!pwrite_q) out_data_q <= sel_rdata;
            psel_q    <= '0;
            penable_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            // Watchdog expiry: report an error, leave read data untouched.
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        default: begin
          psel_q    <= '0;
          penable_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign Ready    = ready_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign OUT_DATA = out_data_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PSTRB    = pstrb_q;

endmodule

// File: tb/tb_apb_multi_slave_bridge.sv
// Testbench for apb_multi_slave_bridge (NUM_SLV=4, 32-bit, TIMEOUT=4).
// Inputs are driven and outputs sampled on the falling edge of PCLK.
module tb_apb_multi_slave_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int TMO = 4;

  logic           PCLK = 1'b0;
  logic           PRESET;
  logic           Trans;
  logic           ReadOrWrite;
  logic [AW-1:0]  Address;
  logic [DW-1:0]  INPUT_DATA;
  logic [3:0]     Input_STRB;
  logic           Ready;
  logic           Done;
  logic [DW-1:0]  OUT_DATA;
  logic           Err;
  logic [NS-1:0]  PSEL;
  logic           PENABLE;
  logic           PWRITE;
  logic [AW-1:0]  PADDR;
  logic [DW-1:0]  PWDATA;
  logic [3:0]     PSTRB;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0]  PREADY;
  logic [NS-1:0]  PSLVERR;

  int checks = 0;
  int fails  = 0;
  logic [DW-1:0] exp_out;

  apb_multi_slave_bridge #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .Trans(Trans), .ReadOrWrite(ReadOrWrite),
    .Address(Address), .INPUT_DATA(INPUT_DATA), .Input_STRB(Input_STRB),
    .Ready(Ready), .Done(Done), .OUT_DATA(OUT_DATA), .Err(Err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Selected slave answers as told; every other slave drives random noise.
  task automatic drive_slaves(input int sel, input bit rdy, input bit serr,
                              input logic [DW-1:0] rd, input bit force_err);
    for (int s = 0; s < NS; s++) begin
      if (s == sel) begin
        PREADY[s]            = rdy;
        PSLVERR[s]           = serr;
        PRDATA[s*DW +: DW]   = rd;
      end else begin
        PREADY[s]            = 1'($urandom_range(1));
        PSLVERR[s]           = force_err ? 1'b1 : 1'($urandom_range(1));
        PRDATA[s*DW +: DW]   = $urandom;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      chk("idle_done", Done, 0);
      chk("idle_err", Err, 0);
      chk("idle_psel", PSEL, 0);
      chk("idle_ready", Ready, 1);
    end
  endtask

  // Present a request (at a falling edge with the bridge idle) and check the
  // setup phase. Returns the selected slave index.
  task automatic start_req(input bit rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [3:0] strb, input bit hold, output int sel);
    sel = int'(addr >> (AW - 2));
    chk("accept_ready", Ready, 1);
    Trans = 1'b1; ReadOrWrite = rd; Address = addr; INPUT_DATA = wdata; Input_STRB = strb;
    @(negedge PCLK);
    // Requester side changes while the bridge is busy must not leak onto the bus.
    Trans = hold; ReadOrWrite = 1'($urandom_range(1)); Address = $urandom;
    INPUT_DATA = $urandom; Input_STRB = 4'($urandom);
    chk("setup_psel", PSEL, 4'b0001 << sel);
    chk("setup_penable", PENABLE, 0);
    chk("setup_pwrite", PWRITE, !rd);
    chk("setup_paddr", PADDR, addr);
    chk("setup_pwdata", PWDATA, wdata);
    chk("setup_pstrb", PSTRB, rd ? 4'b0000 : strb);
    chk("setup_ready", Ready, 0);
    chk("setup_done", Done, 0);
    drive_slaves(sel, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 1'b0);
  endtask

  // One full transfer with 'waits' not-ready ACCESS cycles.
  task automatic run_xfer(input bit rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [3:0] strb, input int waits, input bit serr,
                          input logic [DW-1:0] rdata, input bit hold, input bit force_err);
    int sel;
    start_req(rd, addr, wdata, strb, hold, sel);
    for (int i = 0; i <= waits; i++) begin
      @(negedge PCLK);
      chk("access_penable", PENABLE, 1);
      chk("access_psel", PSEL, 4'b0001 << sel);
      chk("access_paddr", PADDR, addr);
      chk("access_pwdata", PWDATA, wdata);
      chk("access_pstrb", PSTRB, rd ? 4'b0000 : strb);
      chk("access_done", Done, 0);
      chk("access_err", Err, 0);
      if (i == waits) drive_slaves(sel, 1'b1, serr, rdata, force_err);
      else            drive_slaves(sel, 1'b0, 1'($urandom_range(1)), $urandom, force_err);
    end
    @(negedge PCLK);
    if (rd) exp_out = rdata;
    chk("done_pulse", Done, 1);
    chk("done_err", Err, serr);
    chk("done_out_data", OUT_DATA, exp_out);
    chk("done_psel", PSEL, 0);
    chk("done_penable", PENABLE, 0);
    chk("done_ready", Ready, 1);
    drive_slaves(sel, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int sel;
    int done_seen;
    bit hold;
    PRESET = 1'b1; Trans = 1'b0; ReadOrWrite = 1'b0; Address = '0; INPUT_DATA = '0;
    Input_STRB = '0; PRDATA = '0; PREADY = '0; PSLVERR = '0;
    exp_out = '0;
    repeat (2) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb", PSTRB, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_done", Done, 0);
    chk("rst_err", Err, 0);
    chk("rst_ready", Ready, 1);
    PRESET = 1'b0;
    idle_cycles(2);

    // Zero-wait write to slave 2.
    run_xfer(1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0101, 0, 1'b0, $urandom, 1'b0, 1'b0);
    idle_cycles(1);
    // Read from slave 3 with two wait states.
    run_xfer(1'b1, 32'hC000_0004, 32'h0, 4'hF, 2, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    // Write must leave OUT_DATA alone.
    run_xfer(1'b0, 32'h0000_0100, 32'hA5A5_0F0F, 4'hF, 1, 1'b0, $urandom, 1'b0, 1'b0);
    idle_cycles(1);
    // Slave 1 read error while slave 0 flags errors throughout.
    run_xfer(1'b1, 32'h4000_0020, 32'h0, 4'h0, 1, 1'b1, 32'h0BAD_CAFE, 1'b0, 1'b1);
    // Other slaves erroring must not raise Err for a clean slave 2 read.
    run_xfer(1'b1, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0, 32'h7777_1111, 1'b0, 1'b1);
    idle_cycles(1);

    // Trans held high across three back-to-back writes.
    run_xfer(1'b0, 32'h0000_0040, 32'h1111_1111, 4'b0011, 0, 1'b0, $urandom, 1'b1, 1'b0);
    run_xfer(1'b0, 32'h4000_0044, 32'h2222_2222, 4'b1100, 0, 1'b0, $urandom, 1'b1, 1'b0);
    run_xfer(1'b0, 32'hC000_0048, 32'h3333_3333, 4'b1111, 0, 1'b0, $urandom, 1'b1, 1'b0);
    Trans = 1'b0;
    idle_cycles(2);

    // Randomised transfers.
    for (int n = 0; n < 24; n++) begin
      hold = 1'($urandom_range(1));
      run_xfer(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom),
               int'($urandom_range(3)), 1'($urandom_range(1)), $urandom, hold,
               1'($urandom_range(1)));
      if (!hold) idle_cycles(int'($urandom_range(2)));
    end
    Trans = 1'b0;
    idle_cycles(1);

    // Reset in the second ACCESS cycle aborts the transfer silently.
    start_req(1'b1, 32'h4000_0008, 32'h0, 4'h0, 1'b0, sel);
    @(negedge PCLK);
    drive_slaves(sel, 1'b0, 1'b0, $urandom, 1'b0);
    @(negedge PCLK);
    chk("abort_in_access", PENABLE, 1);
    PRESET = 1'b1;
    drive_slaves(sel, 1'b1, 1'b1, 32'hFFFF_0000, 1'b0);
    @(negedge PCLK);
    PRESET = 1'b0;
    exp_out = '0;
    chk("abort_psel", PSEL, 0);
    chk("abort_penable", PENABLE, 0);
    chk("abort_ready", Ready, 1);
    chk("abort_done", Done, 0);
    chk("abort_out_data", OUT_DATA, exp_out);
    drive_slaves(sel, 1'b0, 1'b0, '0, 1'b0);
    idle_cycles(2);

    // Selected slave never becomes ready.
    start_req(1'b1, 32'hC000_0000, 32'h0, 4'h0, 1'b0, sel);
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      @(negedge PCLK);
      chk("tmo_wait_done", Done, 0);
      chk("tmo_wait_penable", PENABLE, 1);
      drive_slaves(sel, 1'b0, 1'b0, $urandom, 1'b0);
    end
    @(negedge PCLK);
    chk("tmo_done", Done, 1);
    chk("tmo_err", Err, 1);
    chk("tmo_out_data", OUT_DATA, exp_out);
    chk("tmo_ready", Ready, 1);
    idle_cycles(2);
`else
    done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (Done === 1'b1) done_seen++;
      drive_slaves(sel, 1'b0, 1'b0, $urandom, 1'b0);
    end
    chk("hang_no_done", done_seen, 0);
    chk("hang_still_access", PENABLE, 1);
    chk("hang_not_ready", Ready, 0);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    chk("hang_reset_ready", Ready, 1);
    idle_cycles(1);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
